// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start(1), 8 data bits LSB first, optional even parity, stop(0); line idles at 0.
// Optional parity slot enabled by defining SERIAL_TX_PARITY_EN.
`timescale 1ns/1ps
module serial_frame_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic [3:0]           frame_slot
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_TC   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t               state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           slot_q, slot_d;
  logic                 tx_q, tx_d;
  logic                 baud_tc;
`ifdef SERIAL_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign baud_tc = (baud_q == BAUD_TC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      shift_q  <= '0;
      slot_q   <= '0;
      tx_q     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      shift_q  <= shift_d;
      slot_q   <= slot_d;
      tx_q     <= tx_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    shift_d  = shift_q;
    slot_d   = slot_q;
    tx_d     = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q != S_IDLE) begin
      baud_d = baud_tc ? '0 : baud_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_d  = S_START;
          shift_d  = tx_data;
          slot_d   = '0;
          baud_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (baud_tc) begin
          state_d = S_DATA;
          slot_d  = 4'd1;
        end
      end
      S_DATA: begin
        if (baud_tc) begin
          shift_d = shift_q >> 1;
          slot_d  = slot_q + 4'd1;
          if (slot_q == LAST_DATA) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (baud_tc) begin
          state_d = S_STOP;
          slot_d  = slot_q + 4'd1;
        end
      end
`endif
      S_STOP: begin
        if (baud_tc) begin
          state_d = S_IDLE;
          slot_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // line value is registered, so it follows the state being entered
    case (state_d)
      S_START:  tx_d = 1'b1;
      S_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b0;
    endcase
  end

  assign tx_ready   = (state_q == S_IDLE);
  assign tx_busy    = ~tx_ready;
  assign tx_out     = tx_q;
  assign frame_slot = slot_q;

endmodule
